vx_raster_quad_compact: RTL and testbench

//  Downstream of the raster quad evaluator. Takes one bundle of NUM_QUADS evaluated quads per

---
 rtl/vx_raster_quad_compact_if.sv | 40 ++++
 rtl/vx_raster_quad_compact.sv | 137 +++++++++++++
 tb/tb_vx_raster_quad_compact.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_raster_quad_compact_if.sv
// Bundle-in / quad-out handshake bundle for the raster quad compactor.
//   Producer side : valid_in, ready_in, pid_in, overlap_in, mask_in, xloc_in, yloc_in, bcoords_in
//   Consumer side : valid_out, ready_out, pid_out, mask_out, xloc_out, yloc_out, bcoords_out
// Modport slave is the compactor itself; modport master is the environment that
// feeds bundles and consumes quads.
interface vx_raster_quad_compact_if #(
    parameter int NUM_QUADS        = 4,
    parameter int RASTER_PID_BITS  = 8,
    parameter int RASTER_DIM_BITS  = 16,
    parameter int RASTER_DATA_BITS = 8
);
    localparam int BC_W = 3 * 4 * RASTER_DATA_BITS;

    logic                                 valid_in;
    logic                                 ready_in;
    logic [RASTER_PID_BITS-1:0]           pid_in;
    logic [NUM_QUADS-1:0]                 overlap_in;
    logic [NUM_QUADS*4-1:0]               mask_in;
    logic [NUM_QUADS*RASTER_DIM_BITS-1:0] xloc_in;
    logic [NUM_QUADS*RASTER_DIM_BITS-1:0] yloc_in;
    logic [NUM_QUADS*BC_W-1:0]            bcoords_in;

    logic                                 valid_out;
    logic                                 ready_out;
    logic [RASTER_PID_BITS-1:0]           pid_out;
    logic [3:0]                           mask_out;
    logic [RASTER_DIM_BITS-1:0]           xloc_out;
    logic [RASTER_DIM_BITS-1:0]           yloc_out;
    logic [BC_W-1:0]                      bcoords_out;

    modport slave (
        input  valid_in, pid_in, overlap_in, mask_in, xloc_in, yloc_in, bcoords_in, ready_out,
        output ready_in, valid_out, pid_out, mask_out, xloc_out, yloc_out, bcoords_out
    );

    modport master (
        output valid_in, pid_in, overlap_in, mask_in, xloc_in, yloc_in, bcoords_in, ready_out,
        input  ready_in, valid_out, pid_out, mask_out, xloc_out, yloc_out, bcoords_out
    );
endinterface

// File: rtl/vx_raster_quad_compact.sv
// Raster quad compactor: accepts one bundle of NUM_QUADS evaluated quads per
// handshake, drops the quads that do not overlap the primitive and emits the
// overlapping ones one per cycle, lowest index first, with valid/ready
// back-pressure. Bundles with no overlapping quad are swallowed without
// producing any output cycle.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset
//   bus        : bundle input / quad output handshake (slave side)
//   busy       : a bundle is held with quads still pending
//   quad_count : running count of emitted quads (wraps at 2^32)
module vx_raster_quad_compact #(
    parameter string INSTANCE_ID      = "",
    parameter int    NUM_QUADS        = 4,
    parameter int    RASTER_PID_BITS  = 8,
    parameter int    RASTER_DIM_BITS  = 16,
    parameter int    RASTER_DATA_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    vx_raster_quad_compact_if.slave    bus,
    output logic                       busy,
    output logic [31:0]                quad_count
);
    localparam int BC_W = 3 * 4 * RASTER_DATA_BITS;
    localparam int DW   = RASTER_DIM_BITS;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                        state_r;
    logic [NUM_QUADS-1:0]          pending_r;
    logic [RASTER_PID_BITS-1:0]    pid_r;
    logic [NUM_QUADS*4-1:0]        mask_r;
    logic [NUM_QUADS*DW-1:0]       xloc_r;
    logic [NUM_QUADS*DW-1:0]       yloc_r;
    logic [NUM_QUADS*BC_W-1:0]     bcoords_r;
    logic [31:0]                   quad_count_r;

    logic [NUM_QUADS-1:0]          sel_onehot_s;
    logic [NUM_QUADS-1:0]          pending_nxt_s;
    logic                          valid_out_s;
    logic                          ready_in_s;
    logic                          fire_in_s;
    logic                          fire_out_s;
    logic                          load_s;
    logic [3:0]                    mask_sel_s;
    logic [DW-1:0]                 xloc_sel_s;
    logic [DW-1:0]                 yloc_sel_s;
    logic [BC_W-1:0]               bcoords_sel_s;

    // Isolates the lowest set bit: v & (-v).
    function automatic logic [NUM_QUADS-1:0] lowest_onehot(input logic [NUM_QUADS-1:0] v);
        logic [NUM_QUADS-1:0] one_v;
        one_v    = {NUM_QUADS{1'b0}};
        one_v[0] = 1'b1;
        return v & (~v + one_v);
    endfunction

    // Handshake decode, pending-bit retirement and the last-quad bypass for ready_in
    always_comb begin
        sel_onehot_s = lowest_onehot(pending_r);
        valid_out_s  = (state_r == ST_HOLD);
        fire_out_s   = valid_out_s & bus.ready_out;
        if (fire_out_s) begin
            pending_nxt_s = pending_r & ~sel_onehot_s;
        end else begin
            pending_nxt_s = pending_r;
        end
        // In HOLD a new bundle may enter only as the single remaining quad leaves.
        case (state_r)
            ST_EMPTY: ready_in_s = 1'b1;
            ST_HOLD:  ready_in_s = (pending_r == sel_onehot_s) & bus.ready_out;
            default:  ready_in_s = 1'b0;
        endcase
        fire_in_s = bus.valid_in & ready_in_s;
        load_s    = fire_in_s & (bus.overlap_in != {NUM_QUADS{1'b0}});
    end

    // One-hot AND-OR mux of the lowest pending quad; all zero when nothing is pending
    always_comb begin
        mask_sel_s    = 4'b0000;
        xloc_sel_s    = {DW{1'b0}};
        yloc_sel_s    = {DW{1'b0}};
        bcoords_sel_s = {BC_W{1'b0}};
        for (int i = 0; i < NUM_QUADS; i++) begin
            mask_sel_s    = mask_sel_s    | ({4{sel_onehot_s[i]}}    & mask_r[i*4 +: 4]);
            xloc_sel_s    = xloc_sel_s    | ({DW{sel_onehot_s[i]}}   & xloc_r[i*DW +: DW]);
            yloc_sel_s    = yloc_sel_s    | ({DW{sel_onehot_s[i]}}   & yloc_r[i*DW +: DW]);
            bcoords_sel_s = bcoords_sel_s | ({BC_W{sel_onehot_s[i]}} & bcoords_r[i*BC_W +: BC_W]);
        end
    end

    // Bundle storage, pending tracking, state and emitted-quad counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_EMPTY;
            pending_r    <= {NUM_QUADS{1'b0}};
            pid_r        <= {RASTER_PID_BITS{1'b0}};
            mask_r       <= {(NUM_QUADS*4){1'b0}};
            xloc_r       <= {(NUM_QUADS*DW){1'b0}};
            yloc_r       <= {(NUM_QUADS*DW){1'b0}};
            bcoords_r    <= {(NUM_QUADS*BC_W){1'b0}};
            quad_count_r <= 32'd0;
        end else begin
            if (load_s) begin
                pid_r     <= bus.pid_in;
                mask_r    <= bus.mask_in;
                xloc_r    <= bus.xloc_in;
                yloc_r    <= bus.yloc_in;
                bcoords_r <= bus.bcoords_in;
                pending_r <= bus.overlap_in;
                state_r   <= ST_HOLD;
            end else begin
                pending_r <= pending_nxt_s;
                state_r   <= (pending_nxt_s != {NUM_QUADS{1'b0}}) ? ST_HOLD : ST_EMPTY;
            end
            if (fire_out_s) begin
                quad_count_r <= quad_count_r + 32'd1;
            end else begin
                quad_count_r <= quad_count_r;
            end
        end
    end

    assign bus.ready_in    = ready_in_s;
    assign bus.valid_out   = valid_out_s;
    assign bus.pid_out     = {RASTER_PID_BITS{valid_out_s}} & pid_r;
    assign bus.mask_out    = mask_sel_s;
    assign bus.xloc_out    = xloc_sel_s;
    assign bus.yloc_out    = yloc_sel_s;
    assign bus.bcoords_out = bcoords_sel_s;
    assign busy            = valid_out_s;
    assign quad_count      = quad_count_r;
endmodule

// File: tb/tb_vx_raster_quad_compact.sv
module tb_vx_raster_quad_compact;
    localparam int NQ = 4;
    localparam int PB = 8;
    localparam int DB = 16;
    localparam int AB = 8;
    localparam int BW = 3 * 4 * AB;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [31:0] quad_count;
    int          total = 0;
    int          bad   = 0;
    int          rmode = 0;
    int          rcnt  = 0;
    int          vc    = 0;

    vx_raster_quad_compact_if #(.NUM_QUADS(NQ), .RASTER_PID_BITS(PB),
        .RASTER_DIM_BITS(DB), .RASTER_DATA_BITS(AB)) bus ();

    vx_raster_quad_compact #(.INSTANCE_ID("tb"), .NUM_QUADS(NQ), .RASTER_PID_BITS(PB),
        .RASTER_DIM_BITS(DB), .RASTER_DATA_BITS(AB)) dut (
        .clk(clk), .reset(rst_n), .bus(bus), .busy(busy), .quad_count(quad_count));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [PB-1:0] pid;
        logic [3:0]    mask;
        logic [DB-1:0] x;
        logic [DB-1:0] y;
        logic [BW-1:0] bc;
    } quad_t;

    quad_t       q[$];
    logic [31:0] m_count = 32'd0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of the quads still owed to the consumer.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_count = 32'd0;
        end else begin
            bit rdy;
            rdy = (q.size() == 0) || (q.size() == 1 && bus.ready_out);
            if (q.size() != 0 && bus.ready_out) begin
                void'(q.pop_front());
                m_count = m_count + 32'd1;
            end
            if (bus.valid_in && rdy) begin
                for (int i = 0; i < NQ; i++) begin
                    if (bus.overlap_in[i]) begin
                        quad_t e;
                        e.pid  = bus.pid_in;
                        e.mask = bus.mask_in[i*4 +: 4];
                        e.x    = bus.xloc_in[i*DB +: DB];
                        e.y    = bus.yloc_in[i*DB +: DB];
                        e.bc   = bus.bcoords_in[i*BW +: BW];
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // Consumer ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = never ready.
    always @(posedge clk) begin
        #1;
        rcnt++;
        case (rmode)
            1:       bus.ready_out = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            2:       bus.ready_out = 1'b0;
            default: bus.ready_out = 1'b1;
        endcase
    end

    // Per-cycle comparison against the model, plus stall stability.
    logic          pv = 1'b0, pr = 1'b0;
    logic [PB-1:0] ppid;
    logic [3:0]    pmask;
    logic [DB-1:0] px, py;
    logic [BW-1:0] pbc;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid_out", bus.valid_out, 0);
            chk("rst_ready_in", bus.ready_in, 1);
            chk("rst_busy", busy, 0);
            chk("rst_count", quad_count, 0);
            chk("rst_data", {bus.pid_out, bus.mask_out, bus.xloc_out, bus.yloc_out}, 0);
            chk("rst_bc", bus.bcoords_out, 0);
            pv = 1'b0;
        end else begin
            bit ev;
            ev = (q.size() != 0);
            chk("valid_out", bus.valid_out, ev);
            chk("busy", busy, ev);
            chk("ready_in", bus.ready_in, (q.size() == 0) || (q.size() == 1 && bus.ready_out));
            chk("quad_count", quad_count, m_count);
            if (ev) begin
                vc++;
                chk("pid_out", bus.pid_out, q[0].pid);
                chk("mask_out", bus.mask_out, q[0].mask);
                chk("xloc_out", bus.xloc_out, q[0].x);
                chk("yloc_out", bus.yloc_out, q[0].y);
                chk("bcoords_out", bus.bcoords_out, q[0].bc);
            end
            if (pv && !pr) begin
                chk("stall_valid", bus.valid_out, 1);
                chk("stall_fields", {bus.pid_out, bus.mask_out, bus.xloc_out, bus.yloc_out},
                    {ppid, pmask, px, py});
                chk("stall_bc", bus.bcoords_out, pbc);
            end
            pv = bus.valid_out; pr = bus.ready_out;
            ppid = bus.pid_out; pmask = bus.mask_out;
            px = bus.xloc_out; py = bus.yloc_out; pbc = bus.bcoords_out;
        end
    end

    // Present one bundle whose fields are a fixed function of (tag, quad index).
    task automatic send(input int tag, input logic [PB-1:0] pid, input logic [NQ-1:0] ov);
        bit acc = 1'b0;
        bus.pid_in     = pid;
        bus.overlap_in = ov;
        for (int i = 0; i < NQ; i++) begin
            bus.mask_in[i*4 +: 4]  = 4'(i * 4 + tag);
            bus.xloc_in[i*DB +: DB] = 16'(tag * 256 + i * 16);
            bus.yloc_in[i*DB +: DB] = 16'(tag * 256 + i * 16 + 8);
            for (int j = 0; j < 12; j++)
                bus.bcoords_in[(i*12 + j)*AB +: AB] = 8'(tag * 32 + i * 12 + j);
        end
        bus.valid_in = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.ready_in;
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0;
        if (!acc) chk("send_accept", acc, 1);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (!bus.valid_out) done = 1'b1;
        end
        chk(name, done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vc0;
        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.pid_in = '0; bus.overlap_in = '0;
        bus.mask_in = '0; bus.xloc_in = '0; bus.yloc_in = '0; bus.bcoords_in = '0;
        bus.ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        @(negedge clk);
        chk("t1_ready_in", bus.ready_in, 1);
        chk("t1_valid_out", bus.valid_out, 0);
        chk("t1_count", quad_count, 32'd0);
        chk("t1_busy", busy, 0);
        @(posedge clk); #1;

        // 2: overlap 1010 -> quads 1 then 3
        send(1, 8'd5, 4'b1010);
        @(negedge clk);
        chk("t2_c1_valid", bus.valid_out, 1);
        chk("t2_c1_ready_in", bus.ready_in, 0);
        chk("t2_c1_pid", bus.pid_out, 8'd5);
        chk("t2_c1_mask", bus.mask_out, 4'h5);
        chk("t2_c1_xloc", bus.xloc_out, 16'h0110);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_c2_ready_in", bus.ready_in, 1);
        chk("t2_c2_mask", bus.mask_out, 4'hd);
        chk("t2_c2_xloc", bus.xloc_out, 16'h0130);
        chk("t2_c2_yloc", bus.yloc_out, 16'h0138);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_count", quad_count, 32'd2);
        chk("t2_done_valid", bus.valid_out, 0);
        @(posedge clk); #1;

        // 3: back-to-back bundles, no bubble
        vc0 = vc;
        send(2, 8'd7, 4'b0001);
        send(3, 8'd8, 4'b0011);
        @(negedge clk);
        chk("t3_c2_pid", bus.pid_out, 8'd8);
        @(posedge clk); #1;
        wait_idle("t3_idle");
        chk("t3_valid_cycles", vc - vc0, 3);
        chk("t3_count", quad_count, 32'd5);

        // 4: zero-overlap bundle is swallowed
        send(4, 8'd9, 4'b0000);
        @(negedge clk);
        chk("t4_valid", bus.valid_out, 0);
        chk("t4_count", quad_count, 32'd5);
        @(posedge clk); #1;

        // 5: full bundle under a stuttering consumer
        rmode = 1;
        send(5, 8'd11, 4'b1111);
        wait_idle("t5_idle");
        chk("t5_count", quad_count, 32'd9);
        rmode = 0;

        // 6: reset with quads pending
        rmode = 2;
        send(6, 8'd12, 4'b0110);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_now", bus.valid_out, 0);
        chk("t6_ready_now", bus.ready_in, 1);
        chk("t6_count_now", quad_count, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rmode = 0;
        repeat (4) @(negedge clk);
        chk("t6_no_stale", bus.valid_out, 0);
        @(posedge clk); #1;

        // Normal operation after reset
        send(7, 8'd13, 4'b1001);
        wait_idle("t7_idle");
        chk("t7_count", quad_count, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
